// File: rtl/score_digit_driver.sv
// Score digit driver: converts the binary score to three BCD digits once per frame
// and streams glyph ROM addresses/pixels for the score window. Optional: LEADING_ZERO_BLANK_EN.
module score_digit_driver #(
  parameter int X_ORIGIN      = 560,
  parameter int Y_ORIGIN      = 8,
  parameter int DIGIT_SPACING = 12
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic [9:0] score,
  input  logic       frame_start,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       display_en,
  input  logic [1:0] number_pixel,
  output logic [4:0] selected_number,
  output logic [7:0] count,
  output logic [1:0] score_pixel,
  output logic       score_active,
  output logic       busy
);
  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;

  logic [9:0]                  bin_q;
  logic [11:0]                 bcd_q;
  logic [3:0]                  iter_q;
  logic [NUM_DIGITS-1:0][3:0]  disp_q;   // [0]=hundreds, [2]=units

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int n = 0; n < 3; n++)
      r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
    return r;
  endfunction

  always_ff @(posedge clock_25) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE:   if (frame_start) state_d = SHIFT;
      SHIFT:  begin busy = 1'b1; if (iter_q == 4'd9) state_d = COMMIT; end
      COMMIT: begin busy = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  logic [11:0] bcd_adj;
  assign bcd_adj = add3(bcd_q);

  always_ff @(posedge clock_25) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      disp_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (frame_start) begin
          bin_q  <= (score > 10'd999) ? 10'd999 : score;
          bcd_q  <= '0;
          iter_q <= '0;
        end
        SHIFT: begin
          bcd_q  <= {bcd_adj[10:0], bin_q[9]};
          bin_q  <= {bin_q[8:0], 1'b0};
          iter_q <= iter_q + 4'd1;
        end
        // Display only ever changes here, so a frame sees either old or new score
        COMMIT: disp_q <= {bcd_q[3:0], bcd_q[7:4], bcd_q[11:8]};
        default: ;
      endcase
    end
  end

  logic [NUM_DIGITS-1:0]      blank;
`ifdef LEADING_ZERO_BLANK_EN
  assign blank[0] = (disp_q[0] == 4'd0);
  assign blank[1] = blank[0] && (disp_q[1] == 4'd0);
  assign blank[2] = 1'b0;
`else
  assign blank = '0;
`endif

  // Per-digit cell hit test and ROM offset
  logic [NUM_DIGITS-1:0]      hit_vec;
  logic [NUM_DIGITS-1:0][7:0] off_vec;
  logic [10:0]                dy;
  logic                       in_rows;

  assign dy      = {1'b0, y_pos} - 11'(Y_ORIGIN);
  assign in_rows = display_en && ({1'b0, y_pos} >= 11'(Y_ORIGIN)) && (dy <= 11'd9);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cell
    localparam logic [10:0] CX = 11'(X_ORIGIN + i*DIGIT_SPACING);
    logic [10:0] dx;
    logic [7:0]  lin;
    assign dx         = {1'b0, x_pos} - CX;
    assign hit_vec[i] = in_rows && ({1'b0, x_pos} >= CX) && (dx <= 11'd9);
    assign lin        = 8'(dy[3:0]) * 8'd10 + 8'(dx[3:0]);
    assign off_vec[i] = {lin[6:0], 1'b0};
  end

  logic       hit_s0, show_s0;
  logic [3:0] dig_s0;
  logic [7:0] off_s0;

  always_comb begin
    hit_s0  = 1'b0;
    show_s0 = 1'b0;
    dig_s0  = '0;
    off_s0  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit_vec[i]) begin
        hit_s0  = 1'b1;
        show_s0 = !blank[i];
        dig_s0  = disp_q[i];
        off_s0  = off_vec[i];
      end
    end
  end

  logic [2:1] vld_pipe;
  logic [2:1] show_pipe;
  logic [7:0] off_q;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      vld_pipe        <= '0;
      show_pipe       <= '0;
      off_q           <= '0;
      selected_number <= '0;
      count           <= '0;
      score_pixel     <= '0;
      score_active    <= 1'b0;
    end else begin
      vld_pipe        <= {vld_pipe[1], hit_s0};
      show_pipe       <= {show_pipe[1], show_s0};
      off_q           <= off_s0;
      selected_number <= hit_s0 ? {1'b0, dig_s0} : 5'd0;
      count           <= vld_pipe[1] ? off_q : 8'd0;
      // ROM glyph for this pixel arrives now, one cycle after count
      score_pixel     <= show_pipe[2] ? number_pixel : 2'b00;
      score_active    <= show_pipe[2];
    end
  end
endmodule

// File: doc/score_digit_driver.md
Name: score_digit_driver

Overview:
- Reader side of the digit glyph ROM (10x10 cells, 2 bits per pixel, 200-bit glyphs, indexed by `selected_number` and bit offset `count`).
- Converts the binary game score into three decimal digits with a sequential shift-add-3 engine, once per frame.
- For each VGA pixel inside the score window, generates the ROM `selected_number`/`count` stream and returns the ROM pixel, aligned with an active flag, to the pixel compositor.

Parameters:
- X_ORIGIN, 560, left column of the hundreds digit cell.
- Y_ORIGIN, 8, top row of all digit cells.
- DIGIT_SPACING, 12, horizontal pitch between digit cell origins in pixels; must be at least 10.

Ports:
- clock_25  in  1  pixel clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- score  in  10  binary score; values above 999 saturate to 999.
- frame_start  in  1  one-cycle pulse at start of vertical blank; requests conversion.
- x_pos  in  10  current pixel column.
- y_pos  in  10  current pixel row.
- display_en  in  1  pixel lies in the visible area.
- number_pixel  in  2  pixel returned by the glyph ROM.
- selected_number  out  5  digit index to the ROM, 0..9.
- count  out  8  ROM bit offset, 2*(row*10+col), 0..198, always even.
- score_pixel  out  2  glyph pixel for the compositor; 00 when not active.
- score_active  out  1  score_pixel belongs to a digit cell.
- busy  out  1  conversion in progress.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; displayed digits are 0,0,0; pipeline registers are cleared.
- Conversion FSM (IDLE, SHIFT, COMMIT):
  - IDLE: on frame_start, load the saturated score into the shift register and clear the BCD accumulator; go to SHIFT; busy=1.
  - SHIFT: runs exactly 10 cycles. Each cycle, first add 3 to any BCD nibble that is 5 or greater, then shift the accumulator and shift register left by one. An iteration counter of 0..9 ends the state.
  - COMMIT: one cycle; copy hundreds/tens/units into the display registers; busy=0 on the next cycle; return to IDLE.
  - Total: 12 cycles from frame_start to updated display registers.
  - frame_start while busy is ignored.
  - Display registers change only in COMMIT, so a frame never shows a half-updated score.
- Hit test for input pixel (x_pos, y_pos):
  - Digit i (0 = hundreds, 1 = tens, 2 = units) is hit when display_en=1, Y_ORIGIN <= y_pos <= Y_ORIGIN+9, and X_ORIGIN+i*DIGIT_SPACING <= x_pos <= that value +9.
  - row = y_pos - Y_ORIGIN; col = x_pos - cell origin.
  - Gap columns and everything outside the cells are not hit.
- Pipeline (the ROM registers its glyph one cycle after `selected_number`; `count` is used combinationally):
  - Edge k+1 (pixel presented in cycle k): `selected_number` is set to the digit value when hit, else 0. The hit flag and offset 2*(row*10+col) are registered internally.
  - Edge k+2: `count` is set to the delayed offset, or 0 when not hit. The hit flag advances.
  - Edge k+3: `score_pixel` is set to `number_pixel` when the flag is set, else 00. `score_active` is set to the flag.
  - Fixed latency: 3 cycles from x_pos/y_pos to score_pixel/score_active.
- Simultaneous events: the conversion engine and the pixel pipeline are independent. A COMMIT during active pixels takes effect on `selected_number` from the next edge. Software issues frame_start in blanking only.
- Reset mid-conversion aborts it; display returns to 000.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a hundreds digit of 0 is blanked. A tens digit of 0 is also blanked when hundreds is blanked. Units is never blanked. For a blanked digit, score_active=0 and score_pixel=00, with the same 3-cycle latency; `selected_number`/`count` still issue.
- Undefined: all three digits always display, leading zeros included.

Test Plan:
- Reset, then scan the window -> selected_number=0 in every cell; score_pixel equals the ROM "0" glyph; busy=0; display 000.
- score=407, frame_start pulse -> busy high 11 cycles; digits become 4,0,7 at cycle 12; hundreds cell issues selected_number=4.
- score=1023 -> digits saturate to 9,9,9.
- Pixel (X_ORIGIN+3, Y_ORIGIN+2) in the hundreds cell -> count=46 two edges after presentation; score_active=1 and score_pixel=number_pixel three edges after.
- Pixel (X_ORIGIN+10, Y_ORIGIN) in the gap, or y_pos=Y_ORIGIN+10 -> score_active=0, score_pixel=00, count=0.
- Second frame_start 5 cycles into a conversion of 250 -> ignored; result 2,5,0 at cycle 12. With LEADING_ZERO_BLANK_EN and score=7 -> only the units cell is active.
